// File: rtl/mem_access.sv
// GeMIPS memory-access stage: the glue between the ex_mem and mem_wb buffers.
// Memory ops are issued on a req/ack data bus. Byte numbering is big-endian.
// The stage stalls upstream while a transfer is outstanding. Non-memory
// instructions pass straight through to the mem_wb inputs.
module mem_access #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_we_o,
  output logic [4:0]  mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_req_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_ack_i
);

  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) + 1 : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hold_q, hold_d;
  logic               err_q, err_d;

  // Op decode
  logic is_load, is_store, is_mem;
  logic sz_byte, sz_half, sz_word, sign_ext;
  logic misaligned;

  // Bus-side values derived from the op and address
  logic [3:0]  be;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Decode the opcode into direction, access size and signedness
  always_comb begin
    is_load  = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
    is_store = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);
    is_mem   = is_load || is_store;
    sz_byte  = (mem_op_i == 4'd1) || (mem_op_i == 4'd2) || (mem_op_i == 4'd6);
    sz_half  = (mem_op_i == 4'd3) || (mem_op_i == 4'd4) || (mem_op_i == 4'd7);
    sz_word  = (mem_op_i == 4'd5) || (mem_op_i == 4'd8);
    sign_ext = (mem_op_i == 4'd1) || (mem_op_i == 4'd3);
    misaligned = (sz_half && mem_addr_i[0]) ||
                 (sz_word && (mem_addr_i[1:0] != 2'b00));
  end

  // Byte enables and replicated store data; lane 0 (addr 0) is bits [31:24]
  always_comb begin
    be         = 4'b0000;
    store_data = 32'h0;
    if (sz_byte) begin
      be = 4'b1000 >> mem_addr_i[1:0];
    end else if (sz_half) begin
      be = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end else if (sz_word) begin
      be = 4'b1111;
    end
    if (is_store) begin
      if (sz_byte)      store_data = {4{mem_sdata_i[7:0]}};
      else if (sz_half) store_data = {2{mem_sdata_i[15:0]}};
      else              store_data = mem_sdata_i;
    end
  end

  // Extract and extend the addressed lane from the captured read word
  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    load_byte = hold_q[31:24];
      2'd1:    load_byte = hold_q[23:16];
      2'd2:    load_byte = hold_q[15:8];
      default: load_byte = hold_q[7:0];
    endcase
    load_half = mem_addr_i[1] ? hold_q[15:0] : hold_q[31:16];
    if (sz_byte)      load_data = {{24{sign_ext & load_byte[7]}}, load_byte};
    else if (sz_half) load_data = {{16{sign_ext & load_half[15]}}, load_half};
    else              load_data = hold_q;
  end

  // Transfer FSM: next state, timeout counter, read capture and all outputs
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    err_d        = err_q;
    mem_we_o     = 1'b0;
    mem_waddr_o  = 5'd0;
    mem_wdata_o  = 32'h0;
    stall_req_o  = 1'b0;
    align_err_o  = 1'b0;
    bus_err_o    = 1'b0;
    data_req_o   = 1'b0;
    data_wr_o    = 1'b0;
    data_addr_o  = 32'h0;
    data_be_o    = 4'b0000;
    data_wdata_o = 32'h0;

    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          mem_we_o    = we_i;
          mem_waddr_o = waddr_i;
          mem_wdata_o = wdata_i;
        end else if (misaligned) begin
          align_err_o = 1'b1;
        end else begin
          data_req_o  = 1'b1;
          stall_req_o = 1'b1;
          cnt_d       = '0;
          err_d       = 1'b0;
          if (data_ack_i) begin
            hold_d  = data_rdata_i;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        data_req_o  = 1'b1;
        stall_req_o = 1'b1;
        if (data_ack_i) begin
          hold_d  = data_rdata_i;
          state_d = DONE;
        end else if ((BUS_TIMEOUT > 0) && ((int'(cnt_q) + 1) >= BUS_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        bus_err_o = err_q;
        if (is_load && !err_q) begin
          mem_we_o    = we_i;
          mem_waddr_o = waddr_i;
          mem_wdata_o = load_data;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus fields come straight from the held ex_mem inputs, so they stay stable across WAIT
    if (data_req_o) begin
      data_wr_o    = is_store;
      data_addr_o  = {mem_addr_i[31:2], 2'b00};
      data_be_o    = be;
      data_wdata_o = store_data;
    end

    // Reset silences every output immediately, not just at the next edge
    if (rst) begin
      mem_we_o     = 1'b0;
      mem_waddr_o  = 5'd0;
      mem_wdata_o  = 32'h0;
      stall_req_o  = 1'b0;
      align_err_o  = 1'b0;
      bus_err_o    = 1'b0;
      data_req_o   = 1'b0;
      data_wr_o    = 1'b0;
      data_addr_o  = 32'h0;
      data_be_o    = 4'b0000;
      data_wdata_o = 32'h0;
    end
  end

  // State, counter, error flag and load-hold register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the hold register is a single word, so clearing it on reset is cheap and keeps stale read data out of a later DONE.
      hold_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

endmodule
